// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for mem_bus_arbiter: size codes, FSM and grant enums, and the
// registered memory-request record with helpers that build it from each bus.
package mem_bus_arbiter_pkg;

    localparam int MEM_ADDR_W = 64;
    localparam int MEM_DATA_W = 64;
    localparam int MEM_STRB_W = MEM_DATA_W / 8;

    typedef enum logic [2:0] {
        MSIZE1 = 3'b000,
        MSIZE2 = 3'b001,
        MSIZE4 = 3'b010,
        MSIZE8 = 3'b011
    } msize_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        IBUS = 1'b0,
        DBUS = 1'b1
    } grant_t;

    typedef struct packed {
        logic                  is_write;
        logic [2:0]            size;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_STRB_W-1:0] strobe;
        logic [MEM_DATA_W-1:0] data;
    } mem_req_t;

    // Instruction fetches are always 4-byte reads.
    function automatic mem_req_t ibus_fetch_req(input logic [MEM_ADDR_W-1:0] addr);
        mem_req_t r;
        r.is_write = 1'b0;
        r.size     = MSIZE4;
        r.addr     = addr;
        r.strobe   = '0;
        r.data     = '0;
        return r;
    endfunction

    function automatic mem_req_t dbus_req(
        input logic [MEM_ADDR_W-1:0] addr,
        input logic [2:0]            size,
        input logic [MEM_STRB_W-1:0] strobe,
        input logic [MEM_DATA_W-1:0] data
    );
        mem_req_t r;
        r.is_write = |strobe;
        r.size     = size;
        r.addr     = addr;
        r.strobe   = strobe;
        r.data     = data;
        return r;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_priority.sv
// Combinational requester pick for mem_bus_arbiter: dbus-first by default,
// alternating on ties when ARB_ROUND_ROBIN_EN is defined.
module arb_priority
    import mem_bus_arbiter_pkg::*;
(
    input  logic   ireq_valid,
    input  logic   dreq_valid,
    input  grant_t last_grant,
    output grant_t grant
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        grant = IBUS;
        if (ireq_valid && dreq_valid) begin
            grant = (last_grant == IBUS) ? DBUS : IBUS;
        end else if (dreq_valid) begin
            grant = DBUS;
        end else begin
            grant = IBUS;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    // The data access belongs to an older instruction, so it goes first.
    always_comb begin
        grant = IBUS;
        if (dreq_valid) begin
            grant = DBUS;
        end else if (ireq_valid) begin
            grant = IBUS;
        end
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between ibus and dbus, one transaction at a time.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternating tie-break).
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                ireq_valid,
    input  logic [ADDR_W-1:0]   ireq_addr,
    output logic                iresp_addr_ok,
    output logic                iresp_data_ok,
    output logic [31:0]         iresp_data,

    input  logic                dreq_valid,
    input  logic [ADDR_W-1:0]   dreq_addr,
    input  logic [2:0]          dreq_size,
    input  logic [DATA_W/8-1:0] dreq_strobe,
    input  logic [DATA_W-1:0]   dreq_data,
    output logic                dresp_addr_ok,
    output logic                dresp_data_ok,
    output logic [DATA_W-1:0]   dresp_data,

    output logic                mreq_valid,
    output logic                mreq_is_write,
    output logic [2:0]          mreq_size,
    output logic [ADDR_W-1:0]   mreq_addr,
    output logic [DATA_W/8-1:0] mreq_strobe,
    output logic [DATA_W-1:0]   mreq_data,
    input  logic                mresp_addr_ok,
    input  logic                mresp_data_ok,
    input  logic [DATA_W-1:0]   mresp_data
);

    arb_state_t state_q, state_d;
    logic       valid_q, valid_d;
    mem_req_t   req_q, req_d;
    grant_t     grant;
    grant_t     last_grant;

`ifdef ARB_ROUND_ROBIN_EN
    grant_t     last_grant_q, last_grant_d;
    assign last_grant = last_grant_q;
`else
    assign last_grant = IBUS;
`endif

    arb_priority u_arb_priority (
        .ireq_valid (ireq_valid),
        .dreq_valid (dreq_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        req_d   = req_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ireq_valid || dreq_valid) begin
                    valid_d = 1'b1;
                    if (grant == DBUS) begin
                        req_d   = dbus_req(MEM_ADDR_W'(dreq_addr), dreq_size,
                                           MEM_STRB_W'(dreq_strobe), MEM_DATA_W'(dreq_data));
                        state_d = ST_GRANT_D;
                    end else begin
                        req_d   = ibus_fetch_req(MEM_ADDR_W'(ireq_addr));
                        state_d = ST_GRANT_I;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = grant;
`endif
                end
            end
            // Request fields stay frozen until the memory returns data.
            ST_GRANT_I, ST_GRANT_D: begin
                if (mresp_data_ok) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            req_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= IBUS;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            req_q   <= req_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    logic granted_i;
    logic granted_d;
    assign granted_i = (state_q == ST_GRANT_I);
    assign granted_d = (state_q == ST_GRANT_D);

    assign mreq_valid    = valid_q;
    assign mreq_is_write = req_q.is_write;
    assign mreq_size     = req_q.size;
    assign mreq_addr     = ADDR_W'(req_q.addr);
    assign mreq_strobe   = (DATA_W/8)'(req_q.strobe);
    assign mreq_data     = DATA_W'(req_q.data);

    // Only the granted side sees handshakes; responses in IDLE are dropped.
    assign iresp_addr_ok = granted_i && mresp_addr_ok;
    assign iresp_data_ok = granted_i && mresp_data_ok;
    assign dresp_addr_ok = granted_d && mresp_addr_ok;
    assign dresp_data_ok = granted_d && mresp_data_ok;

    assign iresp_data = !granted_i   ? 32'h0 :
                        req_q.addr[2] ? mresp_data[63:32] : mresp_data[31:0];
    assign dresp_data = granted_d ? mresp_data : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; expectations follow
// ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                ireq_valid = 1'b0;
    logic [ADDR_W-1:0]   ireq_addr = '0;
    logic                iresp_addr_ok, iresp_data_ok;
    logic [31:0]         iresp_data;
    logic                dreq_valid = 1'b0;
    logic [ADDR_W-1:0]   dreq_addr = '0;
    logic [2:0]          dreq_size = '0;
    logic [DATA_W/8-1:0] dreq_strobe = '0;
    logic [DATA_W-1:0]   dreq_data = '0;
    logic                dresp_addr_ok, dresp_data_ok;
    logic [DATA_W-1:0]   dresp_data;
    logic                mreq_valid, mreq_is_write;
    logic [2:0]          mreq_size;
    logic [ADDR_W-1:0]   mreq_addr;
    logic [DATA_W/8-1:0] mreq_strobe;
    logic [DATA_W-1:0]   mreq_data;
    logic                mresp_addr_ok = 1'b0;
    logic                mresp_data_ok = 1'b0;
    logic [DATA_W-1:0]   mresp_data = '0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .mreq_valid(mreq_valid), .mreq_is_write(mreq_is_write), .mreq_size(mreq_size),
        .mreq_addr(mreq_addr), .mreq_strobe(mreq_strobe), .mreq_data(mreq_data),
        .mresp_addr_ok(mresp_addr_ok), .mresp_data_ok(mresp_data_ok), .mresp_data(mresp_data)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Called in a granted cycle: memory answers at once, then one IDLE cycle follows.
    task automatic serve_grant(input string tag, input logic [63:0] exp_addr, input bit exp_d,
                               input logic [63:0] rdata, input logic [63:0] exp_rdata);
        mresp_addr_ok = 1'b1;
        mresp_data_ok = 1'b1;
        mresp_data    = rdata;
        #1;
        chk({tag, "_mvalid"},   mreq_valid, 1);
        chk({tag, "_addr"},     mreq_addr, exp_addr);
        chk({tag, "_i_addrok"}, iresp_addr_ok, !exp_d);
        chk({tag, "_d_addrok"}, dresp_addr_ok, exp_d);
        chk({tag, "_i_dataok"}, iresp_data_ok, !exp_d);
        chk({tag, "_d_dataok"}, dresp_data_ok, exp_d);
        chk({tag, "_rdata"},    exp_d ? dresp_data : 64'(iresp_data), exp_rdata);
        tick();
        mresp_addr_ok = 1'b0;
        mresp_data_ok = 1'b0;
        #1;
        chk({tag, "_mvalid_fall"}, mreq_valid, 0);
    endtask

    // Requesters must hold their address while valid.
    logic              iv_q = 1'b0, dv_q = 1'b0;
    logic [ADDR_W-1:0] ia_q = '0, da_q = '0;
    always @(posedge clk) begin
        if (reset && ireq_valid && iv_q)
            assert (ireq_addr == ia_q) else $error("protocol violation: ibus address changed while valid");
        if (reset && dreq_valid && dv_q)
            assert (dreq_addr == da_q) else $error("protocol violation: dbus address changed while valid");
        iv_q <= ireq_valid;
        ia_q <= ireq_addr;
        dv_q <= dreq_valid;
        da_q <= dreq_addr;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        tick();
        tick();
        #1;
        chk("rst_mvalid",   mreq_valid, 0);
        chk("rst_maddr",    mreq_addr, 0);
        chk("rst_mwrite",   mreq_is_write, 0);
        chk("rst_i_dataok", iresp_data_ok, 0);
        chk("rst_d_dataok", dresp_data_ok, 0);
        reset = 1'b1;

        // Single fetch, memory answers three cycles after the request appears
        tick();
        ireq_valid = 1'b1;
        ireq_addr  = 64'h8000_0004;
        #1;
        chk("t1_idle_addrok", iresp_addr_ok, 0);
        chk("t1_idle_mvalid", mreq_valid, 0);
        tick();
        mresp_addr_ok = 1'b1;
        #1;
        chk("t1_mvalid",   mreq_valid, 1);
        chk("t1_size",     mreq_size, 3'b010);
        chk("t1_strobe",   mreq_strobe, 0);
        chk("t1_write",    mreq_is_write, 0);
        chk("t1_addr",     mreq_addr, 64'h8000_0004);
        chk("t1_i_addrok", iresp_addr_ok, 1);
        chk("t1_d_addrok", dresp_addr_ok, 0);
        chk("t1_early_ok", iresp_data_ok, 0);
        tick();
        mresp_addr_ok = 1'b0;
        tick();
        tick();
        mresp_data_ok = 1'b1;
        mresp_data    = 64'h1111_2222_3333_4444;
        #1;
        chk("t1_dataok",   iresp_data_ok, 1);
        chk("t1_data",     iresp_data, 32'h1111_2222);
        chk("t1_d_dataok", dresp_data_ok, 0);
        chk("t1_hold",     mreq_addr, 64'h8000_0004);
        tick();
        mresp_data_ok = 1'b0;
        ireq_valid    = 1'b0;
        #1;
        chk("t1_pulse_end", iresp_data_ok, 0);
        chk("t1_mv_fall",   mreq_valid, 0);
        tick();
        #1;
        chk("t1_stay_idle", mreq_valid, 0);

        // Simultaneous requests: dbus first, ibus right after
        for (int r = 0; r < 4; r++) begin
            tick();
            ireq_valid  = 1'b1;
            ireq_addr   = 64'h1000 + 64'(r * 4);
            dreq_valid  = 1'b1;
            dreq_addr   = 64'h2000 + 64'(r * 8);
            dreq_size   = 3'b011;
            dreq_strobe = '0;
            tick();
            serve_grant("rnd_d", 64'h2000 + 64'(r * 8), 1'b1,
                        64'hAAAA_BBBB_CCCC_DDDD, 64'hAAAA_BBBB_CCCC_DDDD);
            dreq_valid = 1'b0;
            tick();
            serve_grant("rnd_i", 64'h1000 + 64'(r * 4), 1'b0, 64'hAAAA_BBBB_CCCC_DDDD,
                        (r % 2 == 1) ? 64'hAAAA_BBBB : 64'hCCCC_DDDD);
            ireq_valid = 1'b0;
        end

        // Both held valid across three grants; last grant so far was ibus
        tick();
        ireq_valid = 1'b1;
        ireq_addr  = 64'h4000;
        dreq_valid = 1'b1;
        dreq_addr  = 64'h5000;
        tick();
        serve_grant("both1", 64'h5000, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
        tick();
        serve_grant("both2", RR ? 64'h4000 : 64'h5000, !RR, 64'h0123_4567_89AB_CDEF,
                    RR ? 64'h89AB_CDEF : 64'h0123_4567_89AB_CDEF);
        if (RR) ireq_valid = 1'b0;
        else    dreq_valid = 1'b0;
        tick();
        serve_grant("both3", RR ? 64'h5000 : 64'h4000, RR, 64'h0123_4567_89AB_CDEF,
                    RR ? 64'h0123_4567_89AB_CDEF : 64'h89AB_CDEF);
        ireq_valid = 1'b0;
        dreq_valid = 1'b0;

        // dbus write; an ibus request arriving mid-transaction must wait
        tick();
        dreq_valid  = 1'b1;
        dreq_addr   = 64'h8000_1000;
        dreq_size   = 3'b011;
        dreq_strobe = 8'hF0;
        dreq_data   = 64'hDEAD_BEEF_0000_0000;
        tick();
        ireq_valid    = 1'b1;
        ireq_addr     = 64'h8000_0008;
        mresp_addr_ok = 1'b1;
        #1;
        chk("wr_write",    mreq_is_write, 1);
        chk("wr_addr",     mreq_addr, 64'h8000_1000);
        chk("wr_strobe",   mreq_strobe, 8'hF0);
        chk("wr_data",     mreq_data, 64'hDEAD_BEEF_0000_0000);
        chk("wr_size",     mreq_size, 3'b011);
        chk("wr_d_addrok", dresp_addr_ok, 1);
        chk("wr_i_addrok", iresp_addr_ok, 0);
        tick();
        mresp_addr_ok = 1'b0;
        tick();
        mresp_data_ok = 1'b1;
        #1;
        chk("wr_d_dataok", dresp_data_ok, 1);
        chk("wr_i_dataok", iresp_data_ok, 0);
        chk("wr_i_wait",   iresp_addr_ok, 0);
        tick();
        mresp_data_ok = 1'b0;
        dreq_valid    = 1'b0;
        dreq_strobe   = '0;
        #1;
        chk("wr_gap_mvalid", mreq_valid, 0);
        tick();
        serve_grant("wr_then_i", 64'h8000_0008, 1'b0, 64'h5555_6666_7777_8888, 64'h7777_8888);
        ireq_valid = 1'b0;

        // Asynchronous reset while dbus is granted
        tick();
        dreq_valid = 1'b1;
        dreq_addr  = 64'h2_0000;
        tick();
        #1;
        chk("rst_mid_mvalid_pre", mreq_valid, 1);
        mresp_addr_ok = 1'b1;
        mresp_data_ok = 1'b1;
        reset         = 1'b0;
        #1;
        chk("rst_mid_mvalid",   mreq_valid, 0);
        chk("rst_mid_d_dataok", dresp_data_ok, 0);
        chk("rst_mid_i_dataok", iresp_data_ok, 0);
        chk("rst_mid_d_addrok", dresp_addr_ok, 0);
        chk("rst_mid_maddr",    mreq_addr, 0);
        mresp_addr_ok = 1'b0;
        mresp_data_ok = 1'b0;
        dreq_valid    = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        ireq_valid = 1'b1;
        ireq_addr  = 64'h3004;
        tick();
        serve_grant("post_rst", 64'h3004, 1'b0, 64'hFEED_FACE_0BAD_F00D, 64'hFEED_FACE);
        ireq_valid = 1'b0;

        // Stray memory response while idle
        tick();
        mresp_data_ok = 1'b1;
        mresp_data    = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("idle_i_dataok", iresp_data_ok, 0);
        chk("idle_d_dataok", dresp_data_ok, 0);
        chk("idle_mvalid",   mreq_valid, 0);
        tick();
        mresp_data_ok = 1'b0;
        #1;
        chk("idle_stay", mreq_valid, 0);
        dreq_valid = 1'b1;
        dreq_addr  = 64'h6000;
        tick();
        serve_grant("idle_next", 64'h6000, 1'b1, 64'h42, 64'h42);
        dreq_valid = 1'b0;

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
